// File: rtl/neuron_mac_if.sv
// neuron_mac_if: activation input stream and result output stream of the
// single-neuron MAC engine.
//   in_valid / in_data / in_ready    : signed N-bit activations into the engine
//   out_valid / out_data / out_ready : signed N-bit saturated result out
// Modports:
//   master : the environment (drives activations, accepts results)
//   slave  : the engine itself
interface neuron_mac_if #(
    parameter int N = 8
);
    logic                in_valid;
    logic signed [N-1:0] in_data;
    logic                in_ready;
    logic                out_valid;
    logic signed [N-1:0] out_data;
    logic                out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate engine fed by a registered
// weights ROM. Weights at base_addr..base_addr+len-1 are multiplied by the
// incoming activations and summed, the bias word at base_addr+len is added
// (aligned to the product's 2Q fractional bits), and the sum is rescaled by
// >>>Q, saturated to N bits and optionally ReLU-clipped.
// Ports:
//   clk, reset      : single clock, asynchronous active-high reset
//   start           : one-cycle request, honoured only while idle
//   base_addr, len  : first weight address and number of inputs (0..255)
//   busy            : high whenever the engine is not idle
//   rom_addr        : registered ROM address (8-bit, wraps)
//   rom_data        : signed weight, valid one posedge after rom_addr changes
//   io (slave)      : activation input stream and result output stream
module neuron_mac #(
    parameter int N     = 8,
    parameter int Q     = 7,
    parameter int ACC_W = 24,
    parameter int RELU  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          base_addr,
    input  logic [7:0]          len,
    output logic                busy,
    output logic [7:0]          rom_addr,
    input  logic signed [N-1:0] rom_data,
    neuron_mac_if.slave         io
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_BIAS  = 3'd4,
        S_SAT   = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [7:0]              base_r;
    logic [7:0]              len_r;
    logic [7:0]              idx_r;
    logic [7:0]              rom_addr_r;
    logic signed [2*N-1:0]   prod_r;
    logic                    prod_v_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [N-1:0]     out_data_r;
    logic                    out_valid_r;
    logic                    in_ready_r;
    logic                    busy_r;

    logic                    launch_s;
    logic                    accept_s;
    logic signed [2*N-1:0]   w_ext_s;
    logic signed [2*N-1:0]   x_ext_s;
    logic signed [2*N-1:0]   mul_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [ACC_W-1:0] scaled_s;
    logic signed [N-1:0]     sat_s;
    logic signed [N-1:0]     result_s;

    // Clamp a rescaled accumulator value into the signed N-bit range.
    // In range exactly when all bits from N-1 upward equal the sign bit.
    function automatic logic signed [N-1:0] sat_n(input logic signed [ACC_W-1:0] v);
        logic signed [N-1:0] r;
        if (!v[ACC_W-1] && (|v[ACC_W-2:N-1])) begin
            r = {1'b0, {(N-1){1'b1}}};
        end else if (v[ACC_W-1] && !(&v[ACC_W-2:N-1])) begin
            r = {1'b1, {(N-1){1'b0}}};
        end else begin
            r = v[N-1:0];
        end
        return r;
    endfunction

    assign busy         = busy_r;
    assign rom_addr     = rom_addr_r;
    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus the launch / accept strobes used by the datapath.
    always_comb begin
        next_state_s = state_r;
        launch_s     = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    launch_s     = 1'b1;
                    next_state_s = S_PRIME;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_PRIME: begin
                // With len=0 the word at base_addr is already the bias.
                if (len_r != 8'd0) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_BIAS;
                end
            end
            S_RUN: begin
                if (io.in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    if (idx_r == (len_r - 8'd1)) begin
                        next_state_s = S_DRAIN;
                    end else begin
                        next_state_s = S_RUN;
                    end
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_DRAIN: next_state_s = S_BIAS;
            S_BIAS:  next_state_s = S_SAT;
            S_SAT:   next_state_s = S_OUT;
            S_OUT: begin
                if (io.out_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_OUT;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Arithmetic: product, aligned bias, accumulator update and rescale/saturate.
    always_comb begin
        w_ext_s    = {{N{rom_data[N-1]}}, rom_data};
        x_ext_s    = {{N{io.in_data[N-1]}}, io.in_data};
        mul_s      = w_ext_s * x_ext_s;
        prod_ext_s = {{(ACC_W-2*N){prod_r[2*N-1]}}, prod_r};
        // Bias carries Q fractional bits; shift by Q to match the products' 2Q.
        bias_ext_s = {{(ACC_W-N-Q){rom_data[N-1]}}, rom_data, {Q{1'b0}}};
        if (launch_s) begin
            acc_next_s = {ACC_W{1'b0}};
        end else if (state_r == S_BIAS) begin
            acc_next_s = acc_r + bias_ext_s;
        end else if (prod_v_r) begin
            acc_next_s = acc_r + prod_ext_s;
        end else begin
            acc_next_s = acc_r;
        end
        scaled_s = acc_r >>> Q;
        sat_s    = sat_n(scaled_s);
        if ((RELU != 0) && sat_s[N-1]) begin
            result_s = {N{1'b0}};
        end else begin
            result_s = sat_s;
        end
    end

    // Operand bookkeeping: latched request, input index, ROM address, product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r     <= 8'd0;
            len_r      <= 8'd0;
            idx_r      <= 8'd0;
            rom_addr_r <= 8'd0;
            prod_r     <= {(2*N){1'b0}};
            prod_v_r   <= 1'b0;
            acc_r      <= {ACC_W{1'b0}};
        end else begin
            prod_v_r <= accept_s;
            acc_r    <= acc_next_s;
            if (launch_s) begin
                base_r     <= base_addr;
                len_r      <= len;
                idx_r      <= 8'd0;
                rom_addr_r <= base_addr;
            end else if (accept_s) begin
                idx_r      <= idx_r + 8'd1;
                // After the last accept this lands on the bias address.
                rom_addr_r <= base_r + idx_r + 8'd1;
                prod_r     <= mul_s;
            end else begin
                idx_r      <= idx_r;
                rom_addr_r <= rom_addr_r;
            end
        end
    end

    // Registered handshake outputs: result hold, in_ready and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r  <= {N{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s == S_RUN);
            busy_r     <= (next_state_s != S_IDLE);
            if (state_r == S_SAT) begin
                out_data_r  <= result_s;
                out_valid_r <= 1'b1;
            end else if ((state_r == S_OUT) && io.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate engine that sits directly downstream of the weights ROM. It drives the ROM address and consumes the registered signed weight it returns. It multiplies each weight by an incoming activation and accumulates the products, then adds a bias word fetched from the same ROM. The result is rescaled, saturated and optionally ReLU-clipped to N-bit Q-format, then presented on a valid/ready output.

## Interface
- N, 8, activation/weight/output width (signed, Q fractional bits)
- Q, 7, fractional bits of every N-bit operand
- ACC_W, 24, accumulator width; must be ≥ 2N+8
- RELU, 0, 1 = clamp negative results to 0
- clk  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  8  ROM address of the first weight
- len  in  8  number of inputs, 0..255
- busy  out  1  high whenever state ≠ IDLE
- rom_addr  out  8  registered address to the weights ROM
- rom_data  in  N  signed weight from the ROM, valid one posedge after rom_addr changes
- in_valid  in  1  activation valid
- in_data  in  N  signed activation
- in_ready  out  1  activation accepted when in_valid & in_ready at posedge
- out_valid  out  1  result valid, held until accepted
- out_data  out  N  signed saturated result
- out_ready  in  1  downstream accept

## Operation
- Reset values:
  - state=IDLE; rom_addr=0; out_valid=0; out_data=0; in_ready=0; busy=0.
  - Accumulator, index and product registers = 0.
- ROM contract: the ROM registers on negedge. A rom_addr updated at posedge t yields matching rom_data at posedge t+1.
- States:
  - IDLE → PRIME on start.
    - Latch base_addr/len, clear acc and idx, rom_addr ← base_addr.
    - start is ignored in every other state.
  - PRIME (1 cycle): wait for the first ROM word.
    - → RUN if len>0.
    - → BIAS if len=0; rom_data then already holds the bias at base_addr.
  - RUN: in_ready=1.
    - On each accept, prod ← rom_data × in_data (2N-bit signed), prod_v ← 1, idx++, rom_addr ← base_addr+idx+1 (mod 256).
    - Back-to-back accepts give full throughput.
    - When prod_v=1 at a posedge, acc ← acc + sign-extended prod.
    - On the accept with idx=len-1 → DRAIN. rom_addr is now base_addr+len, the bias address.
  - DRAIN (1 cycle): accumulate the final prod. → BIAS.
  - BIAS (1 cycle): acc ← acc + (sign-extended rom_data <<< Q). → SAT.
  - SAT (1 cycle): out_data ← sat_N(acc >>> Q), then ReLU if RELU=1; out_valid ← 1. → OUT.
  - OUT: out_data/out_valid held stable.
    - On out_valid & out_ready → IDLE, out_valid ← 0.
    - A start in that same cycle is ignored.
- Arithmetic rules:
  - Products carry 2Q fractional bits; the bias is aligned by <<<Q.
  - Rescale is an arithmetic right shift by Q (floor, no rounding).
  - Saturation bounds: [-2^(N-1), 2^(N-1)-1].
  - With ACC_W ≥ 2N+8 the accumulator cannot overflow for len ≤ 255. No wrap handling is required.
- Address arithmetic is 8-bit and wraps: base_addr+len > 255 wraps to low addresses.
- in_valid gaps stall RUN indefinitely. The accumulator and rom_addr hold.
- Reset mid-operation aborts immediately to the reset values. No output is produced.

## Timing
- start at posedge t0 → PRIME at t0+1 → in_ready high during cycle t0+1. The first accept can occur at posedge t0+2.
- For len>0, last accept at posedge tL:
  - DRAIN edge tL+1.
  - BIAS edge tL+2.
  - out_valid high after tL+3.
- For len=0, start at t0 → out_valid high after t0+3.
- Minimum total for len=k with continuous in_valid: out_valid after t0+k+4.
- in_ready is registered from state and is low outside RUN. It drops in the cycle after the final accept.
- busy falls in the cycle after the output handshake.

## Test plan
- Single input, N=8, Q=7: len=1, w=64, x=64, bias=0 → out_data=32, out_valid 3 cycles after the accept.
- Positive saturation: len=3 back-to-back, w=127, x=127, bias=127 → acc=64643 → out_data=127. Check in_ready drops after the 3rd accept.
- Negative path: len=3, w=127, x=-128, bias=0 → out_data=-128. Same with len=1, w=64, x=-128 → out_data=-64 for RELU=0 and 0 for RELU=1.
- len=0, bias word=-5 at base_addr → out_data=-5 three cycles after start; in_ready never asserted.
- Flow control: len=4 with in_valid gaps of 0-3 cycles, out_ready low for 5 cycles, start pulsed while busy. Required:
  - Result identical to the gap-free run.
  - out_data stable while out_ready is low.
  - No restart from the ignored start pulses.
  - base_addr=254 wraps rom_addr to 0 and 1, bias at 2.
- Reset asserted during RUN after 2 of 4 accepts → all outputs at reset values asynchronously. A subsequent start runs cleanly from acc=0.
